countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable 7-bit down-counter with a load handshake, count enable, abort and a one-cycle terminal-count pulse. It is the decrementing counterpart of the team's free-running 7-bit up counter. It sits beside that counter wherever a block must wait a programmed number of enabled cycles, such as timeouts, pulse stretching or periodic ticks. A single clock domain is used throughout.

## Interface
Parameters:
- WIDTH, 7, counter and load-value width in bits

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- load  input  1  load request, qualified by load_ready
- load_val  input  WIDTH  start value, captured when load && load_ready
- load_ready  output  1  high when a load is accepted (state IDLE)
- en  input  1  count enable; the counter decrements only when high
- abort  input  1  stop the count, return to IDLE, no terminal pulse
- q  output  WIDTH  current count (registered)
- busy  output  1  high in state RUN
- zero  output  1  combinational (q == 0)
- tc  output  1  registered terminal-count pulse, exactly one cycle wide

## Operation
- Reset is synchronous and active-high. The clock and reset ports are CLK and Reset.
- Reset values: q=0, state IDLE, reload_reg=0, tc=0, busy=0, load_ready=1, zero=1.
- Reset has priority over every other input and takes effect mid-count.
- State machine: IDLE, RUN.
- IDLE:
  - load_ready=1, busy=0.
  - When load is high: q<=load_val and reload_reg<=load_val.
  - If load_val!=0, go to RUN.
  - If load_val==0, stay IDLE and pulse tc on the next cycle (a zero-length timer expires immediately).
  - en and abort are ignored in IDLE.
- RUN:
  - load_ready=0, busy=1, and load is ignored.
  - Priority order: abort > en > hold.
  - abort: q<=0, go to IDLE, tc stays 0. This holds even if the same edge would have been terminal.
  - en with q>1: q<=q-1.
  - en with q==1 is terminal: q<=0, tc<=1, go to IDLE. The auto-reload variant is covered under Configuration.
  - en low: q holds its value and the state does not change.
- Arithmetic: the decrement is WIDTH-bit unsigned. q is never 0 while in RUN, so underflow cannot occur.
- Expiry time: load value N (1..2^WIDTH−1) expires after exactly N enabled cycles.
- tc is 0 on every cycle except the single cycle following a terminal event or a zero-valued load.

## Timing
- Load latency: q shows load_val on the cycle after the accepting edge. busy rises on that same cycle when load_val!=0.
- Decrement: with en held high, q steps by one on every edge.
- Terminal event: tc=1 on the same cycle that q first shows 0 (or the reload value), and for that one cycle only.
- Once back in IDLE, load_ready=1 on that same cycle. A new load is accepted on the next edge, so a load can be taken back-to-back with tc.
- All outputs except zero are registered. zero is decoded from q and has no added latency.

## Configuration
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Undefined (default): one-shot. A terminal event returns the block to IDLE with q=0.
- Defined: periodic mode.
  - A terminal event in RUN sets q<=reload_reg, pulses tc, and the block stays in RUN.
  - The period is N enabled cycles per tc.
  - abort and Reset are the only exits from RUN.
  - q never shows 0 in RUN.
  - A zero-valued load behaves the same as in one-shot mode.

## Test plan
- Reset, then load_val=5 with en=1 throughout:
  - q sequence is 5,4,3,2,1,0.
  - tc=1 only on the cycle q=0.
  - busy drops and load_ready=1 on that same cycle.
- load_val=3, with en toggled 1,0,1,0,1:
  - q sequence is 3,2,2,1,1,0.
  - tc asserts once, after 3 enabled cycles.
- load_val=0:
  - q stays 0, the block stays IDLE with busy=0.
  - tc pulses exactly one cycle, on the cycle after the load.
- Abort cases:
  - load_val=10, abort asserted when q=4: q=0 and IDLE on the next cycle, tc never asserts.
  - Repeat with abort and en both high when q=1: tc must stay 0.
- Reset and load-ignore cases:
  - load_val=100 (7'h64), with Reset asserted when q=50: next cycle q=0, busy=0, tc=0, load_ready=1.
  - load asserted during RUN must not change q.
- With COUNTDOWN_AUTO_RELOAD_EN, load_val=3 and en=1 for 12 cycles:
  - q sequence is 3,2,1,3,2,1,3,…
  - tc high on each cycle q returns to 3 after 1, i.e. every 3 cycles.
  - busy stays 1 until abort.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter. It counts a programmed number of enabled cycles and
// then emits a single-cycle terminal-count pulse. It is the decrementing
// companion of the free-running up counter, used for timeouts, pulse
// stretching and periodic ticks. Everything runs in one clock domain.
//
// Build option:
//   COUNTDOWN_AUTO_RELOAD_EN  When defined, the timer is periodic. A terminal
//                             event reloads the last loaded value and stays in
//                             RUN. When undefined (the default), it is
//                             one-shot and returns to IDLE with q=0.
//
// Parameters:
//   WIDTH       counter and load-value width in bits (default 7)
//
// Ports:
//   CLK         in   clock; all state updates on the rising edge
//   Reset       in   synchronous active-high reset; overrides every input
//   load        in   load request, accepted only while load_ready is high
//   load_val    in   start value, captured on an accepted load
//   load_ready  out  high in IDLE, when a load is accepted
//   en          in   count enable; RUN decrements only when high
//   abort       in   leave RUN for IDLE with q=0 and no terminal pulse
//   q           out  current count (registered)
//   busy        out  high in RUN
//   zero        out  combinational decode of q == 0
//   tc          out  registered terminal-count pulse, one cycle wide
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 7
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Unsigned decrement. The caller only uses it while q > 1, so it never wraps.
  function automatic logic [WIDTH-1:0] dec1(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  // Next-state logic for the counter and the FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tc_d     = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          cnt_d = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          reload_d = load_val;
`endif
          // A zero-length load expires immediately and never enters RUN.
          if (load_val != '0) state_d = RUN;
          else                tc_d    = 1'b1;
        end
      end
      RUN: begin
        // abort wins over a terminal event on the same edge.
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (en) begin
          if (cnt_q == WIDTH'(1)) begin
            tc_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            cnt_d = reload_q;
`else
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            cnt_d = dec1(cnt_q);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Register stage: everything visible on the ports except zero
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tc_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q          = cnt_q;
  assign tc         = tc_q;
  assign busy       = (state_q == RUN);
  assign load_ready = (state_q == IDLE);
  assign zero       = (cnt_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed bench for countdown_timer. Each step drives the inputs for one
// clock edge and pushes the outputs expected after that edge onto a
// scoreboard queue. After the edge the entry is popped and compared with the
// DUT outputs.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int W = 7;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         load_ready;
  logic         en = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         zero;
  logic         tc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .load       (load),
    .load_val   (load_val),
    .load_ready (load_ready),
    .en         (en),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .zero       (zero),
    .tc         (tc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, queue the expected post-edge outputs, and check them.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic e,
                      input logic ab, input logic rs,
                      input logic [W-1:0] eq, input logic eb, input logic et,
                      input string tag);
    exp_t x;
    load = ld; load_val = lv; en = e; abort = ab; Reset = rs;
    x.q = eq; x.busy = eb; x.tc = et;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, ".q"},          32'(q),          32'(x.q));
      chk({tag, ".busy"},       32'(busy),       32'(x.busy));
      chk({tag, ".load_ready"}, 32'(load_ready), 32'(!x.busy));
      chk({tag, ".tc"},         32'(tc),         32'(x.tc));
      chk({tag, ".zero"},       32'(zero),       32'(x.q == '0));
    end
  endtask

  initial begin
    // Reset
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, "reset");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "after_reset");

    // Zero-valued load: immediate tc, no RUN (same in both modes)
    step(1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, "zload");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "zload_after");

    // en and abort are ignored in IDLE
    step(1'b0, 7'd9, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "idle_ignore");

    // Abort at q=4 from load 10
    step(1'b1, 7'd10, 1'b0, 1'b0, 1'b0, 7'd10, 1'b1, 1'b0, "ab_load");
    for (int i = 1; i <= 6; i++)
      step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, W'(10 - i), 1'b1, 1'b0, "ab_dec");
    step(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "ab_q4");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "ab_after");

    // Abort together with en at q=1 must suppress tc
    step(1'b1, 7'd2, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, "abt_load");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, "abt_dec");
    step(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "abt_q1");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "abt_after");

    // Reset mid-count: load 100 and count down to 50
    step(1'b1, 7'd100, 1'b0, 1'b0, 1'b0, 7'd100, 1'b1, 1'b0, "rst_load");
    for (int i = 1; i <= 50; i++)
      step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, W'(100 - i), 1'b1, 1'b0, "rst_dec");
    step(1'b1, 7'd33, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, "rst_mid");

    // load during RUN is ignored
    step(1'b1, 7'd20, 1'b0, 1'b0, 1'b0, 7'd20, 1'b1, 1'b0, "li_load");
    step(1'b1, 7'd5,  1'b0, 1'b0, 1'b0, 7'd20, 1'b1, 1'b0, "li_hold");
    step(1'b1, 7'd5,  1'b1, 1'b0, 1'b0, 7'd19, 1'b1, 1'b0, "li_dec");
    step(1'b0, 7'd0,  1'b0, 1'b1, 1'b0, 7'd0,  1'b0, 1'b0, "li_abort");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // One-shot: load 5 with en held high -> 5,4,3,2,1,0
    step(1'b1, 7'd5, 1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 1'b0, "os5_load");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd4, 1'b1, 1'b0, "os5_4");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, "os5_3");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, "os5_2");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, "os5_1");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, "os5_0");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "os5_after");

    // Gapped enable: load 3, en 1,0,1,0,1 -> 3,2,2,1,1,0
    step(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, "gap_load");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, "gap_e1");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, "gap_e0");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, "gap_e1b");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, "gap_e0b");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, "gap_term");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "gap_after");

    // Back-to-back: load accepted on the edge after the tc cycle
    step(1'b1, 7'd2, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, "b2b_load");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, "b2b_dec");
    step(1'b1, 7'd7, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, "b2b_term");
    step(1'b1, 7'd7, 1'b0, 1'b0, 1'b0, 7'd7, 1'b1, 1'b0, "b2b_reload");
    step(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "b2b_abort");

    // Maximum load value counts down fully
    step(1'b1, 7'd127, 1'b1, 1'b0, 1'b0, 7'd127, 1'b1, 1'b0, "max_load");
    for (int i = 1; i <= 126; i++)
      step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, W'(127 - i), 1'b1, 1'b0, "max_dec");
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, "max_term");
`else
    // Periodic: load 3 with en high -> 3,2,1,3,2,1,... tc each time 3 returns
    step(1'b1, 7'd3, 1'b1, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, "ar_load");
    for (int i = 1; i <= 12; i++)
      step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, W'(3 - (i % 3)), 1'b1,
           ((i % 3) == 0), "ar_cyc");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, "ar_hold");
    step(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "ar_abort");
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, "ar_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
